// File: rtl/sync_fifo_param.sv
// Single-clock parametrised elastic FIFO with occupancy count, threshold flags and sticky errors.
// Latency: standard mode data_out is valid 1 cycle after rd_en; FWFT shows the head word 1 cycle after the write.
// Backpressure: writes while full and reads while empty are dropped and latched as overflow/underflow.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    input  logic              flush,
    input  logic              clr_err,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W+1)'(AE_THRESH);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_params
        $error("sync_fifo_param: illegal thresholds AF=%0d AE=%0d for DEPTH=%0d", AF_THRESH, AE_THRESH, DEPTH);
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_ok;
    logic              rd_ok;

    // Flush outranks both requests so a flushing cycle never moves data or raises errors.
    assign wr_ok = wr_en & ~full  & ~flush;
    assign rd_ok = rd_en & ~empty & ~flush;

    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error event beats a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full & ~flush)      overflow <= 1'b1;
            else if (clr_err)               overflow <= 1'b0;
            if (rd_en & empty & ~flush)     underflow <= 1'b1;
            else if (clr_err)               underflow <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem[rd_ptr];
    end else begin : g_std
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)   data_out <= '0;
            else if (rd_ok) data_out <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_flush = 1'b0, f_clr_err = 1'b0;
    logic [7:0] f_data_in = '0;
    logic [7:0] f_data_out;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_std (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out), .flush(flush), .clr_err(clr_err), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .ADDR_W(4), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_fw (
        .clk(clk), .reset_n(reset_n), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .flush(f_flush), .clr_err(f_clr_err), .full(f_full), .empty(f_empty),
        .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    // One clock of stimulus on the standard instance; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic fl = 1'b0, input logic ce = 1'b0);
        wr_en = w; data_in = d; rd_en = r; flush = fl; clr_err = ce;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    task automatic fcyc(input logic w, input logic [7:0] d, input logic r);
        f_wr_en = w; f_data_in = d; f_rd_en = r;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100)
            $display("FAIL reset_flags got %b exp 1100", {empty, almost_empty, full, almost_full}); else n_pass++;
        n_checks++; if ({overflow, underflow} !== 2'b00)
            $display("FAIL reset_err got %b exp 00", {overflow, underflow}); else n_pass++;
        n_checks++; if (data_out !== 8'h00) $display("FAIL reset_dout got %h exp 00", data_out); else n_pass++;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            n_checks++; if (count !== 5'(i + 1)) $display("FAIL fill_count got %0d exp %0d", count, i + 1); else n_pass++;
            n_checks++; if (almost_full !== (i + 1 >= 12))
                $display("FAIL fill_af at count %0d got %b exp %b", i + 1, almost_full, (i + 1 >= 12)); else n_pass++;
        end
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full got %b exp 1", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf got %b exp 0", overflow); else n_pass++;
        cyc(1'b1, 8'd4, 1'b0);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_set got %b exp 1", overflow); else n_pass++;
        n_checks++; if (count !== 5'd16) $display("FAIL ovf_count got %0d exp 16", count); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_checks++; if (data_out !== 8'(i)) $display("FAIL drain_data got %h exp %h", data_out, 8'(i)); else n_pass++;
            n_checks++; if (almost_empty !== (15 - i <= 4))
                $display("FAIL drain_ae at count %0d got %b exp %b", 15 - i, almost_empty, (15 - i <= 4)); else n_pass++;
        end
        n_checks++; if ({empty, almost_empty, count} !== {2'b11, 5'd0})
            $display("FAIL drain_empty got e=%b ae=%b cnt=%0d exp e=1 ae=1 cnt=0", empty, almost_empty, count); else n_pass++;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %b exp 0", overflow); else n_pass++;
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_checks++; if (data_out !== 8'(8'h10 + i)) $display("FAIL wrap_pre got %h exp %h", data_out, 8'(8'h10 + i)); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(8'hA0 + i), 1'b0);
            n_checks++; if (count !== 5'(i + 1)) $display("FAIL wrap_count got %0d exp %0d", count, i + 1); else n_pass++;
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            n_checks++; if (data_out !== 8'(8'hA0 + i)) $display("FAIL wrap_data got %h exp %h", data_out, 8'(8'hA0 + i)); else n_pass++;
        end
        n_checks++; if ({empty, overflow, underflow} !== 3'b100)
            $display("FAIL wrap_end got %b exp 100", {empty, overflow, underflow}); else n_pass++;
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h60 + i), 1'b1);
            n_checks++; if (count !== 5'd5) $display("FAIL simul_count got %0d exp 5", count); else n_pass++;
            n_checks++; if (data_out !== 8'(8'h50 + i)) $display("FAIL simul_data got %h exp %h", data_out, 8'(8'h50 + i)); else n_pass++;
        end
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0);
        n_checks++; if (full !== 1'b1) $display("FAIL simul_full got %b exp 1", full); else n_pass++;
        cyc(1'b1, 8'hEE, 1'b1);
        n_checks++; if (count !== 5'd15) $display("FAIL full_rw_count got %0d exp 15", count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL full_rw_ovf got %b exp 1", overflow); else n_pass++;
        n_checks++; if (data_out !== 8'h54) $display("FAIL full_rw_data got %h exp 54", data_out); else n_pass++;
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_checks++; if ({count, overflow} !== {5'd0, 1'b0})
            $display("FAIL flush_clr got cnt=%0d ovf=%b exp cnt=0 ovf=0", count, overflow); else n_pass++;
        cyc(1'b1, 8'h11, 1'b1);
        n_checks++; if (count !== 5'd1) $display("FAIL empty_rw_count got %0d exp 1", count); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL empty_rw_unf got %b exp 1", underflow); else n_pass++;
        n_checks++; if (data_out !== 8'h54) $display("FAIL empty_rw_hold got %h exp 54", data_out); else n_pass++;
    endtask

    task automatic test_flush_clear;
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b0) $display("FAIL clr_unf got %b exp 0", underflow); else n_pass++;
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        n_checks++; if (count !== 5'd7) $display("FAIL pre_flush_count got %0d exp 7", count); else n_pass++;
        cyc(1'b1, 8'hFF, 1'b0, 1'b1);
        n_checks++; if ({count, empty, overflow} !== {5'd0, 1'b1, 1'b0})
            $display("FAIL flush_wr got cnt=%0d e=%b ovf=%b exp cnt=0 e=1 ovf=0", count, empty, overflow); else n_pass++;
        n_checks++; if (data_out !== 8'h54) $display("FAIL flush_dout got %h exp 54", data_out); else n_pass++;
        cyc(1'b0, 8'h00, 1'b1, 1'b1);
        n_checks++; if (underflow !== 1'b0) $display("FAIL flush_rd_unf got %b exp 0", underflow); else n_pass++;
        cyc(1'b0, 8'h00, 1'b1);
        n_checks++; if (underflow !== 1'b1) $display("FAIL unf_set got %b exp 1", underflow); else n_pass++;
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        n_checks++; if (underflow !== 1'b1) $display("FAIL set_wins got %b exp 1", underflow); else n_pass++;
        cyc(1'b1, 8'h33, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        n_checks++; if (data_out !== 8'h33) $display("FAIL post_flush_data got %h exp 33", data_out); else n_pass++;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        n_checks++; if ({count, underflow} !== {5'd9, 1'b1})
            $display("FAIL pre_rst got cnt=%0d unf=%b exp cnt=9 unf=1", count, underflow); else n_pass++;
        #2 reset_n = 1'b0;
        #2;
        n_checks++; if (count !== 5'd0) $display("FAIL arst_count got %0d exp 0", count); else n_pass++;
        n_checks++; if ({empty, almost_empty, full, almost_full, overflow, underflow} !== 6'b110000)
            $display("FAIL arst_flags got %b exp 110000",
                     {empty, almost_empty, full, almost_full, overflow, underflow}); else n_pass++;
        n_checks++; if (data_out !== 8'h00) $display("FAIL arst_dout got %h exp 00", data_out); else n_pass++;
        @(posedge clk); #3 reset_n = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 8'hC5, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        n_checks++; if ({data_out, empty} !== {8'hC5, 1'b1})
            $display("FAIL post_rst got d=%h e=%b exp d=c5 e=1", data_out, empty); else n_pass++;
    endtask

    task automatic test_fwft;
        n_checks++; if (f_empty !== 1'b1) $display("FAIL fwft_init_empty got %b exp 1", f_empty); else n_pass++;
        fcyc(1'b1, 8'h3C, 1'b0);
        n_checks++; if (f_empty !== 1'b0) $display("FAIL fwft_empty got %b exp 0", f_empty); else n_pass++;
        n_checks++; if (f_data_out !== 8'h3C) $display("FAIL fwft_head got %h exp 3c", f_data_out); else n_pass++;
        fcyc(1'b1, 8'h5A, 1'b0);
        n_checks++; if ({f_data_out, f_count} !== {8'h3C, 5'd2})
            $display("FAIL fwft_hold got d=%h cnt=%0d exp d=3c cnt=2", f_data_out, f_count); else n_pass++;
        fcyc(1'b0, 8'h00, 1'b1);
        n_checks++; if ({f_data_out, f_count} !== {8'h5A, 5'd1})
            $display("FAIL fwft_adv got d=%h cnt=%0d exp d=5a cnt=1", f_data_out, f_count); else n_pass++;
        fcyc(1'b0, 8'h00, 1'b1);
        n_checks++; if ({f_empty, f_underflow} !== 2'b10)
            $display("FAIL fwft_drain got %b exp 10", {f_empty, f_underflow}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_flush_clear();
        test_fwft();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
